setpoint_ramp: RTL and testbench
================================

SETPOINT_RAMP -- requirements
Module: setpoint_ramp

Interface
REQ-001 Parameter: DW, 16, data width of target and output channels (signed two's complement).
REQ-002 Parameter: SW, 8, width of the unsigned step-size input.
REQ-003 Parameter: OW, 8, width of the overrun counter.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 left_tgt  input  DW  signed left-channel target, from the direction-control stage's left_frwd.
REQ-007 right_tgt  input  DW  signed right-channel target, from the direction-control stage's right_back.
REQ-008 tick  input  1  one-cycle control-period strobe.
REQ-009 step  input  SW  unsigned maximum magnitude change per tick.
REQ-010 out_ready  input  1  downstream consumer accepts the current output.
REQ-011 left_out  output  DW  signed ramped left value.
REQ-012 right_out  output  DW  signed ramped right value.
REQ-013 out_valid  output  1  left_out/right_out hold a new, unconsumed sample.
REQ-014 settled  output  1  both outputs equal the last captured targets.
REQ-015 overrun_cnt  output  OW  count of ticks dropped while a sample was unconsumed.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE and PRESENT.
REQ-017 In IDLE, tick=1 SHALL capture left_tgt/right_tgt, update both outputs per REQ-019, and enter PRESENT on the next edge.
REQ-018 Latency: tick in cycle N -> new outputs with out_valid=1 in cycle N+1.
REQ-019 Per channel: d = tgt - cur, computed at DW+1 bits signed; if |d| <= step then cur := tgt; else cur := cur + step when d>0, or cur - step when d<0.
REQ-020 Step arithmetic SHALL be done at DW+1 bits; the result never passes the target, so no saturation is required and no wrap-around is permitted.
REQ-021 step=0 SHALL leave both outputs unchanged, while still producing a valid sample.
REQ-022 In PRESENT, out_valid SHALL be 1, and left_out/right_out SHALL be held stable.
REQ-023 In PRESENT, out_valid=1 with out_ready=1 SHALL complete the handshake, and the FSM SHALL return to IDLE on the next edge.
REQ-024 In PRESENT, tick=1 without handshake completion SHALL drop the tick, increment overrun_cnt, and leave the outputs unchanged.
REQ-025 In PRESENT, tick=1 in the handshake cycle SHALL also be dropped and counted; no tick is queued.
REQ-026 overrun_cnt SHALL saturate at 2^OW-1, with no wrap.
REQ-027 settled SHALL be registered, and SHALL be 1 iff left_out==captured left target and right_out==captured right target.
REQ-028 Target inputs SHALL be sampled only on accepted ticks; changes between ticks have no effect.
REQ-029 Out_ready in IDLE SHALL be ignored.

Reset
REQ-030 reset=1 at an edge SHALL force FSM=IDLE, left_out=0, right_out=0, captured targets=0, out_valid=0, settled=1, and overrun_cnt=0.
REQ-031 Reset SHALL take priority over tick and handshake in the same cycle, and SHALL abort any ramp or pending sample mid-operation.
REQ-032 In the first cycle after reset deasserts, the block SHALL accept a tick normally.

Verification
REQ-033 Ramp: from reset, left_tgt=-102, right_tgt=102, step=40, out_ready=1, tick every 4 cycles -> (left,right) = (-40,40), (-80,80), (-102,102); settled=1 only after the third sample.
REQ-034 Backpressure: sample pending, out_ready=0, 3 ticks -> overrun_cnt=3, outputs and out_valid stable; out_ready=1 -> IDLE next cycle.
REQ-035 Extremes: cur=-32768, left_tgt=32767, step=255 -> left_out=-32513 with no overflow; repeated ticks reach 32767 exactly.
REQ-036 Step zero: step=0, target 218, tick -> out_valid=1, outputs unchanged, settled=0.
REQ-037 Reset mid-ramp: outputs at (-80,80) with out_valid=1, assert reset -> next cycle outputs 0, out_valid=0, overrun_cnt=0, settled=1.
REQ-038 Saturation: with OW=8, 300 dropped ticks -> overrun_cnt=255.

Source files
------------

// File: rtl/setpoint_ramp_if.sv
// Output channel of the setpoint ramp: ramped left/right sample plus a valid/ready handshake.
interface setpoint_ramp_if #(
  parameter int DW = 16
);
  logic signed [DW-1:0] left_out;
  logic signed [DW-1:0] right_out;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output left_out, right_out, out_valid, input out_ready);
  modport slave  (input left_out, right_out, out_valid, output out_ready);
endinterface

// File: rtl/setpoint_ramp.sv
// Rate-limits left/right setpoints toward captured targets once per control tick and
// presents each new sample on a valid/ready channel, counting ticks lost to backpressure.
module setpoint_ramp #(
  parameter int DW = 16,
  parameter int SW = 8,
  parameter int OW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] left_tgt,
  input  logic signed [DW-1:0] right_tgt,
  input  logic                 tick,
  input  logic [SW-1:0]        step,
  setpoint_ramp_if.master      out_if,
  output logic                 settled,
  output logic [OW-1:0]        overrun_cnt
);

  typedef enum logic [0:0] {
    IDLE_S    = 1'b0,
    PRESENT_S = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 accept_s;
  logic                 drop_s;
  logic signed [DW-1:0] left_r;
  logic signed [DW-1:0] right_r;
  logic signed [DW-1:0] ltgt_r;
  logic signed [DW-1:0] rtgt_r;
  logic signed [DW-1:0] left_nxt_s;
  logic signed [DW-1:0] right_nxt_s;
  logic signed [DW-1:0] left_d_s;
  logic signed [DW-1:0] right_d_s;
  logic signed [DW-1:0] ltgt_d_s;
  logic signed [DW-1:0] rtgt_d_s;
  logic                 out_valid_r;
  logic                 settled_r;
  logic [OW-1:0]        ovr_r;

  // One extra bit keeps tgt-cur and cur+/-step exact; the move never overshoots the target.
  function automatic logic [DW-1:0] ramp_step(input logic [DW-1:0] cur,
                                              input logic [DW-1:0] tgt,
                                              input logic [SW-1:0] stp);
    logic signed [DW:0] cur_x;
    logic signed [DW:0] d_x;
    logic signed [DW:0] mag_x;
    logic signed [DW:0] stp_x;
    cur_x = $signed({cur[DW-1], cur});
    d_x   = $signed({tgt[DW-1], tgt}) - cur_x;
    mag_x = d_x[DW] ? -d_x : d_x;
    stp_x = $signed({{(DW+1-SW){1'b0}}, stp});
    if (mag_x <= stp_x) begin
      ramp_step = tgt;
    end else if (d_x[DW] == 1'b0) begin
      ramp_step = DW'(cur_x + stp_x);
    end else begin
      ramp_step = DW'(cur_x - stp_x);
    end
  endfunction

  // Next-state decode: accept ticks in IDLE, drop them while a sample is pending.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      IDLE_S: begin
        if (tick) begin
          accept_s    = 1'b1;
          state_nxt_s = PRESENT_S;
        end else begin
          state_nxt_s = IDLE_S;
        end
      end
      PRESENT_S: begin
        drop_s = tick;
        if (out_if.out_ready) begin
          state_nxt_s = IDLE_S;
        end else begin
          state_nxt_s = PRESENT_S;
        end
      end
      default: begin
        state_nxt_s = IDLE_S;
      end
    endcase
  end

  // Candidate ramp values and the register contents they would produce.
  always_comb begin
    left_nxt_s  = ramp_step(left_r, left_tgt, step);
    right_nxt_s = ramp_step(right_r, right_tgt, step);
    if (accept_s) begin
      left_d_s  = left_nxt_s;
      right_d_s = right_nxt_s;
      ltgt_d_s  = left_tgt;
      rtgt_d_s  = right_tgt;
    end else begin
      left_d_s  = left_r;
      right_d_s = right_r;
      ltgt_d_s  = ltgt_r;
      rtgt_d_s  = rtgt_r;
    end
  end

  // State, datapath and status registers; reset wins over every other action.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE_S;
      left_r      <= {DW{1'b0}};
      right_r     <= {DW{1'b0}};
      ltgt_r      <= {DW{1'b0}};
      rtgt_r      <= {DW{1'b0}};
      out_valid_r <= 1'b0;
      settled_r   <= 1'b1;
      ovr_r       <= {OW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      left_r      <= left_d_s;
      right_r     <= right_d_s;
      ltgt_r      <= ltgt_d_s;
      rtgt_r      <= rtgt_d_s;
      out_valid_r <= (state_nxt_s == PRESENT_S);
      settled_r   <= (left_d_s == ltgt_d_s) && (right_d_s == rtgt_d_s);
      if (drop_s && (ovr_r != {OW{1'b1}})) begin
        ovr_r <= ovr_r + {{(OW-1){1'b0}}, 1'b1};
      end else begin
        ovr_r <= ovr_r;
      end
    end
  end

  assign out_if.left_out  = left_r;
  assign out_if.right_out = right_r;
  assign out_if.out_valid = out_valid_r;
  assign settled          = settled_r;
  assign overrun_cnt      = ovr_r;

endmodule

// File: tb/tb_setpoint_ramp.sv
// Scoreboard bench for setpoint_ramp: directed scenarios followed by randomized traffic,
// all checked against an integer reference model of the ramp/handshake rules.
module tb_setpoint_ramp;
  localparam int DW = 16;
  localparam int SW = 8;
  localparam int OW = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] left_tgt;
  logic signed [DW-1:0] right_tgt;
  logic                 tick;
  logic [SW-1:0]        step;
  logic                 settled;
  logic [OW-1:0]        overrun_cnt;

  setpoint_ramp_if #(.DW(DW)) bus ();

  setpoint_ramp #(.DW(DW), .SW(SW), .OW(OW)) dut (
    .clk        (clk),
    .reset      (reset),
    .left_tgt   (left_tgt),
    .right_tgt  (right_tgt),
    .tick       (tick),
    .step       (step),
    .out_if     (bus),
    .settled    (settled),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int l;
    int r;
    bit s;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // reference model state
  int m_cl = 0, m_cr = 0, m_tl = 0, m_tr = 0, m_ovr = 0;
  bit m_pend = 1'b0, m_set = 1'b1;

  function automatic int ramp_to(int cur, int tgt, int stp);
    int d = tgt - cur;
    int a = (d < 0) ? -d : d;
    if (a <= stp) return tgt;
    return (d > 0) ? cur + stp : cur - stp;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: applies the effect of each rising edge using the inputs present at that edge
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_cl = 0; m_cr = 0; m_tl = 0; m_tr = 0;
        m_pend = 1'b0; m_set = 1'b1; m_ovr = 0;
        sbq.delete();
      end else if (!m_pend) begin
        if (tick) begin
          exp_t e;
          m_tl  = int'(left_tgt);
          m_tr  = int'(right_tgt);
          m_cl  = ramp_to(m_cl, m_tl, int'(step));
          m_cr  = ramp_to(m_cr, m_tr, int'(step));
          m_set = (m_cl == m_tl) && (m_cr == m_tr);
          m_pend = 1'b1;
          e.l = m_cl; e.r = m_cr; e.s = m_set;
          sbq.push_back(e);
        end
      end else begin
        if (tick && m_ovr < 255) m_ovr = m_ovr + 1;
        if (bus.out_ready) m_pend = 1'b0;
      end
    end
  end

  // monitor: mid-cycle status checks, and scoreboard pop on every completed handshake
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", int'(bus.out_valid), int'(m_pend));
      chk("left_out", int'(bus.left_out), m_cl);
      chk("right_out", int'(bus.right_out), m_cr);
      chk("settled", int'(settled), int'(m_set));
      chk("overrun_cnt", int'(overrun_cnt), m_ovr);
      if (bus.out_valid && bus.out_ready && !reset) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: got handshake expected no sample at %0t", $time);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_left", int'(bus.left_out), e.l);
          chk("sb_right", int'(bus.right_out), e.r);
          chk("sb_settled", int'(settled), int'(e.s));
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0;
    cyc(1);
    reset = 1'b0;
  endtask

  int exp_l[3] = '{-40, -80, -102};

  initial begin
    reset = 1'b1; tick = 1'b0; step = 8'd0;
    left_tgt = 16'sd0; right_tgt = 16'sd0; bus.out_ready = 1'b0;
    cyc(2);
    chk("rst_left", int'(bus.left_out), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_settled", int'(settled), 1);
    chk("rst_ovr", int'(overrun_cnt), 0);
    reset = 1'b0;

    // ramp toward (-102,102) in steps of 40, tick accepted in first cycle after reset
    left_tgt = -16'sd102; right_tgt = 16'sd102; step = 8'd40; bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      chk("ramp_left", int'(bus.left_out), exp_l[k]);
      chk("ramp_right", int'(bus.right_out), -exp_l[k]);
      chk("ramp_valid", int'(bus.out_valid), 1);
      chk("ramp_settled", int'(settled), (k == 2) ? 1 : 0);
      cyc(3);
    end

    // backpressure and reset mid-ramp
    do_reset();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(2);
    bus.out_ready = 1'b0;
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("bp_left", int'(bus.left_out), -80);
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    end
    chk("bp_ovr", int'(overrun_cnt), 3);
    chk("bp_left_hold", int'(bus.left_out), -80);
    chk("bp_valid_hold", int'(bus.out_valid), 1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("midrst_left", int'(bus.left_out), 0);
    chk("midrst_valid", int'(bus.out_valid), 0);
    chk("midrst_ovr", int'(overrun_cnt), 0);
    chk("midrst_settled", int'(settled), 1);

    // release after backpressure returns to IDLE next cycle
    tick = 1'b1; cyc(1); tick = 1'b0;
    bus.out_ready = 1'b1; cyc(1);
    chk("release_valid", int'(bus.out_valid), 0);

    // step zero still produces a sample
    do_reset();
    step = 8'd0; left_tgt = 16'sd218; right_tgt = 16'sd218;
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("step0_valid", int'(bus.out_valid), 1);
    chk("step0_left", int'(bus.left_out), 0);
    chk("step0_settled", int'(settled), 0);
    cyc(1);

    // extremes: drive left to -32768, then ramp all the way to 32767
    step = 8'd255; left_tgt = -16'sd32768; right_tgt = 16'sd32767;
    for (int k = 0; k < 130; k++) begin
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    end
    chk("ext_min", int'(bus.left_out), -32768);
    left_tgt = 16'sd32767;
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("ext_first", int'(bus.left_out), -32513);
    cyc(1);
    for (int k = 0; k < 256; k++) begin
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    end
    chk("ext_max", int'(bus.left_out), 32767);
    chk("ext_settled", int'(settled), 1);

    // overrun counter saturation
    bus.out_ready = 1'b0;
    tick = 1'b1; cyc(1);
    cyc(300);
    tick = 1'b0;
    chk("ovr_sat", int'(overrun_cnt), 255);
    bus.out_ready = 1'b1; cyc(2);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 63) == 0);
      tick  = ($urandom_range(0, 2) == 0);
      step  = ($urandom_range(0, 7) == 0) ? 8'd0 : SW'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        left_tgt  = DW'($urandom);
        right_tgt = DW'($urandom);
      end
      bus.out_ready = $urandom_range(0, 1) == 1;
      cyc(1);
    end
    reset = 1'b0; tick = 1'b0; bus.out_ready = 1'b1;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
